display_prefetch: RTL and testbench

- Scanout read controller sitting between the display timing generator and SRAM arbiter port 0, the highest-priority port.
- Walks the front framebuffer linearly, one 32-bit word per arbiter transaction, and stores the words in an internal show-ahead FIFO.
- The display pixel path pops words from that FIFO.
- Refill hysteresis batches the arbiter requests, leaving idle gaps for the framebuffer-write, Z and texture ports.

---
 rtl/display_pkg.sv | 24 ++
 rtl/display_prefetch_fifo.sv | 70 +++++++
 rtl/display_prefetch.sv | 195 +++++++++++++++++++
 tb/tb_display_prefetch.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : display_pkg
//  Description : Shared constants and the prefetch state encoding for the
//                display scanout prefetch controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package display_pkg;

    localparam int c_ADDR_W      = 24;
    localparam int c_FRAME_WORDS = 153600;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_WAIT_ACK = 3'd2,
        ST_CAPTURE  = 3'd3,
        ST_HOLD     = 3'd4,
        ST_DONE     = 3'd5,
        ST_DRAIN    = 3'd6
    } pf_state_t;

endpackage
`default_nettype wire

// File: rtl/display_prefetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : prefetch_fifo
//  Description : Synchronous show-ahead FIFO. The head word is presented
//                combinationally whenever the FIFO is non-empty; flush has
//                priority over push and pop.
//  Revision    : 1.0 - initial release
// ============================================================================
module prefetch_fifo
    import display_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    input  logic                   pop,
    input  logic                   flush,
    output logic [$clog2(DEPTH):0] level,
    output logic                   empty,
    output logic                   full,
    output logic [WIDTH-1:0]       head
);

    localparam int                c_PTR_W = $clog2(DEPTH);
    localparam logic [c_PTR_W:0]  c_FULL  = (c_PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W:0]   r_level;

    logic w_do_push;
    logic w_do_pop;

    assign empty     = (r_level == '0);
    assign full      = (r_level == c_FULL);
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    // Pointer and occupancy bookkeeping; flush empties the FIFO in one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_level  <= '0;
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_level <= r_level + (c_PTR_W+1)'(w_do_push) - (c_PTR_W+1)'(w_do_pop);
        end
    end

    // Storage array, written only on an accepted push
    always_ff @(posedge clk) begin
        if (w_do_push && !flush) r_mem[r_wr_ptr] <= din;
    end

    // Show-ahead head; forced to zero when empty so stale words never leak out
    assign head  = empty ? '0 : r_mem[r_rd_ptr];
    assign level = r_level;

endmodule
`default_nettype wire

// File: rtl/display_prefetch.sv
`default_nettype none
// ============================================================================
//  Module      : display_prefetch
//  Description : Scanout read controller. Walks the front framebuffer one
//                word per arbiter transaction, buffers the words in a
//                show-ahead FIFO for the pixel path, and batches requests
//                with full/refill hysteresis.
//                Optional: define DISPLAY_PREFETCH_UNDERRUN_CNT_EN to add a
//                16-bit saturating underrun counter output (underrun_cnt).
//  Revision    : 1.0 - initial release
// ============================================================================
module display_prefetch
    import display_pkg::*;
#(
    parameter int ADDR_W        = c_ADDR_W,
    parameter int FIFO_DEPTH    = 32,
    parameter int FRAME_WORDS   = c_FRAME_WORDS,
    parameter int REFILL_THRESH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic                          frame_start,
    input  logic [ADDR_W-1:0]             fb_base,
    output logic                          mem_req,
    output logic                          mem_we,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [31:0]                   mem_wdata,
    input  logic [31:0]                   mem_rdata,
    input  logic                          mem_ack,
    input  logic                          pix_pop,
    output logic [31:0]                   pix_data,
    output logic                          pix_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          frame_done,
`ifdef DISPLAY_PREFETCH_UNDERRUN_CNT_EN
    output logic [15:0]                   underrun_cnt,
`endif
    output logic                          underrun
);

    localparam int                 c_LVL_W     = $clog2(FIFO_DEPTH) + 1;
    localparam int                 c_CNT_W     = $clog2(FRAME_WORDS + 1);
    localparam logic [c_CNT_W-1:0] c_FRAME_END = c_CNT_W'(FRAME_WORDS);
    localparam logic [c_LVL_W-1:0] c_FULL_LVL  = c_LVL_W'(FIFO_DEPTH);
    localparam logic [c_LVL_W-1:0] c_THRESH    = c_LVL_W'(REFILL_THRESH);

    pf_state_t          r_state;
    logic [ADDR_W-1:0]  r_addr;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [c_CNT_W-1:0] r_word_cnt;
    logic               r_mem_req;
    logic               r_frame_done;
    logic               r_underrun;

    logic [c_LVL_W-1:0] w_level;
    logic [c_LVL_W-1:0] w_eff;
    logic               w_empty;
    logic               w_full;
    logic               w_inflight;
    logic               w_room;
    logic               w_push;
    logic [31:0]        w_head;

    // A word is in flight from request issue until its capture cycle
    assign w_inflight = (r_state == ST_WAIT_ACK) || (r_state == ST_CAPTURE) ||
                        (r_state == ST_DRAIN);
    assign w_eff      = w_level + c_LVL_W'(w_inflight);
    assign w_room     = !w_full && (w_eff < c_FULL_LVL);
    // A frame restart during capture discards the returning word
    assign w_push     = (r_state == ST_CAPTURE) && !frame_start;

    prefetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .din   (mem_rdata),
        .pop   (pix_pop),
        .flush (frame_start),
        .level (w_level),
        .empty (w_empty),
        .full  (w_full),
        .head  (w_head)
    );

    // Fetch sequencer: frame restart, request issue, capture and refill hysteresis
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_addr       <= '0;
            r_mem_addr   <= '0;
            r_word_cnt   <= '0;
            r_mem_req    <= 1'b0;
            r_frame_done <= 1'b0;
        end else if (frame_start) begin
            r_addr       <= fb_base;
            r_word_cnt   <= '0;
            r_frame_done <= 1'b0;
            if (r_mem_req) begin
                // Outstanding request must still be completed before refetching
                if (mem_ack) begin
                    r_mem_req <= 1'b0;
                    r_state   <= ST_FETCH;
                end else begin
                    r_state   <= ST_DRAIN;
                end
            end else begin
                r_state <= ST_FETCH;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_IDLE;
                end
                ST_FETCH: begin
                    if (enable && w_room && (r_word_cnt < c_FRAME_END)) begin
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= r_addr;
                        r_state    <= ST_WAIT_ACK;
                    end else if (r_word_cnt == c_FRAME_END) begin
                        r_frame_done <= 1'b1;
                        r_state      <= ST_DONE;
                    end else if (!w_room) begin
                        r_state <= ST_HOLD;
                    end
                end
                ST_WAIT_ACK: begin
                    if (mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_state   <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    r_addr     <= r_addr + 1'b1;
                    r_word_cnt <= r_word_cnt + 1'b1;
                    r_state    <= ST_FETCH;
                end
                ST_HOLD: begin
                    if (w_level <= c_THRESH) r_state <= ST_FETCH;
                end
                ST_DONE: begin
                    r_state <= ST_DONE;
                end
                ST_DRAIN: begin
                    if (mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_state   <= ST_FETCH;
                    end
                end
                default: begin
                    r_mem_req <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    // Underrun flag: pop requested while nothing is buffered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_underrun <= 1'b0;
        else        r_underrun <= pix_pop && w_empty;
    end

`ifdef DISPLAY_PREFETCH_UNDERRUN_CNT_EN
    logic [15:0] r_underrun_cnt;

    // Saturating per-frame underrun count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_underrun_cnt <= '0;
        end else if (frame_start) begin
            r_underrun_cnt <= '0;
        end else if (pix_pop && w_empty && (r_underrun_cnt != 16'hFFFF)) begin
            r_underrun_cnt <= r_underrun_cnt + 16'd1;
        end
    end

    assign underrun_cnt = r_underrun_cnt;
`endif

    assign mem_req    = r_mem_req;
    assign mem_we     = 1'b0;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = '0;
    assign pix_data   = w_head;
    assign pix_valid  = !w_empty;
    assign fifo_level = w_level;
    assign frame_done = r_frame_done;
    assign underrun   = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_display_prefetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_display_prefetch
//  Description : Scoreboard bench for display_prefetch. A randomized arbiter
//                returns a known word per address; a monitor compares every
//                request address and every popped pixel word against the
//                linear frame walk expected from fb_base.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_display_prefetch;

    localparam int FW    = 40;
    localparam int DEPTH = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        frame_start;
    logic [23:0] fb_base;
    logic        mem_req;
    logic        mem_we;
    logic [23:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        pix_pop;
    logic [31:0] pix_data;
    logic        pix_valid;
    logic [5:0]  fifo_level;
    logic        frame_done;
    logic        underrun;
`ifdef DISPLAY_PREFETCH_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt;
    int          exp_ucnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // arbiter controls
    int fixed_dly = -1;
    int stray_ack = 0;

    // scoreboard state
    logic [31:0] exp_pix [$];
    logic [23:0] mon_base;
    int          req_idx;
    int          active;
    logic        prev_req;
    logic [23:0] last_addr;
    logic        pred_ur;

    always #5 clk = ~clk;

    display_prefetch #(
        .ADDR_W        (24),
        .FIFO_DEPTH    (DEPTH),
        .FRAME_WORDS   (FW),
        .REFILL_THRESH (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .frame_start  (frame_start),
        .fb_base      (fb_base),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ack      (mem_ack),
        .pix_pop      (pix_pop),
        .pix_data     (pix_data),
        .pix_valid    (pix_valid),
        .fifo_level   (fifo_level),
        .frame_done   (frame_done),
`ifdef DISPLAY_PREFETCH_UNDERRUN_CNT_EN
        .underrun_cnt (underrun_cnt),
`endif
        .underrun     (underrun)
    );

    // Memory contents as seen through the arbiter: a tagged copy of the address
    function automatic logic [31:0] fword(input logic [23:0] a);
        return {~a[7:0], a};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_frame(input logic [23:0] base);
        fb_base     = base;
        frame_start = 1'b1;
        pix_pop     = 1'b0;
        tick();
        frame_start = 1'b0;
    endtask

    // Arbiter model: random ack latency, data returned the cycle after ack
    initial begin : arbiter
        int          dly;
        logic        give;
        logic [31:0] pend;
        dly = -1; give = 1'b0; pend = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        forever begin
            tick();
            mem_ack   = 1'b0;
            mem_rdata = give ? pend : $urandom;
            give      = 1'b0;
            if (!rst_n) begin
                dly = -1;
            end else if (stray_ack != 0) begin
                mem_ack   = 1'b1;
                stray_ack = 0;
            end else if (mem_req) begin
                if (dly < 0) dly = (fixed_dly >= 0) ? fixed_dly : int'($urandom_range(0, 3));
                if (dly == 0) begin
                    mem_ack = 1'b1;
                    pend    = fword(mem_addr);
                    give    = 1'b1;
                    dly     = -1;
                end else begin
                    dly--;
                end
            end
        end
    end

    // Monitor: request order/addresses, popped words, underrun pulses
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_pix.delete();
            active   = 0;
            req_idx  = 0;
            prev_req = 1'b0;
            pred_ur  = 1'b0;
`ifdef DISPLAY_PREFETCH_UNDERRUN_CNT_EN
            exp_ucnt = 0;
`endif
        end else begin
            chk("underrun", {31'b0, underrun}, {31'b0, pred_ur});
            pred_ur = pix_pop && !pix_valid;
            chk("valid_vs_level", {31'b0, pix_valid}, {31'b0, fifo_level != 6'd0});
            chk("we_wdata", {31'b0, mem_we} | mem_wdata, 32'h0);
`ifdef DISPLAY_PREFETCH_UNDERRUN_CNT_EN
            chk("underrun_cnt", {16'b0, underrun_cnt}, exp_ucnt);
            if (frame_start) exp_ucnt = 0;
            else if (pred_ur && exp_ucnt != 16'hFFFF) exp_ucnt++;
`endif
            if (mem_req && !prev_req) begin
                if (active == 0 || req_idx >= FW) begin
                    chk("req_unexpected", {8'b0, mem_addr}, 32'hFFFFFFFF);
                end else begin
                    logic [23:0] ea;
                    ea = mon_base + 24'(req_idx);
                    chk("req_addr", {8'b0, mem_addr}, {8'b0, ea});
                end
                req_idx++;
            end else if (mem_req) begin
                chk("addr_stable", {8'b0, mem_addr}, {8'b0, last_addr});
            end
            last_addr = mem_addr;
            prev_req  = mem_req;
            if (pix_pop && pix_valid && !frame_start) begin
                if (exp_pix.size() == 0) chk("pix_extra", pix_data, 32'hDEADBEEF ^ pix_data ^ 32'h1);
                else                     chk("pix_data", pix_data, exp_pix.pop_front());
            end
            if (frame_start) begin
                active   = 1;
                mon_base = fb_base;
                req_idx  = 0;
                exp_pix.delete();
                for (int i = 0; i < FW; i++) exp_pix.push_back(fword(fb_base + 24'(i)));
            end
        end
    end

    // Stimulus and directed checks
    initial begin : driver
        int   any_req;
        int   seen;
        rst_n = 1'b0; enable = 1'b0; frame_start = 1'b0; fb_base = '0; pix_pop = 1'b0;
        repeat (3) tick();
        chk("rst_mem_req",    {31'b0, mem_req}, 0);
        chk("rst_mem_addr",   {8'b0, mem_addr}, 0);
        chk("rst_pix_data",   pix_data, 0);
        chk("rst_pix_valid",  {31'b0, pix_valid}, 0);
        chk("rst_fifo_level", {26'b0, fifo_level}, 0);
        chk("rst_frame_done", {31'b0, frame_done}, 0);
        chk("rst_underrun",   {31'b0, underrun}, 0);
        rst_n = 1'b1;
        tick();

        // Basic fetch: fill the FIFO with no pops
        enable = 1'b1;
        pulse_frame(24'h001000);
        for (int i = 0; i < 400 && fifo_level != 6'd32; i++) tick();
        chk("fill_level", {26'b0, fifo_level}, 32);
        any_req = 0;
        repeat (10) begin tick(); if (mem_req) any_req = 1; end
        chk("full_no_req", any_req, 0);

        // Refill hysteresis: 15 pops leave level 17, no refetch
        pix_pop = 1'b1;
        repeat (15) begin tick(); if (mem_req) any_req = 1; end
        pix_pop = 1'b0;
        repeat (6) begin tick(); if (mem_req) any_req = 1; end
        chk("hyst_no_req", any_req, 0);
        chk("hyst_level", {26'b0, fifo_level}, 17);
        pix_pop = 1'b1;
        tick();
        pix_pop = 1'b0;
        seen = 0;
        repeat (3) begin tick(); if (mem_req) seen = 1; end
        chk("hyst_resume", seen, 1);

        // Frame end: exactly FW requests, then silence
        for (int i = 0; i < 300 && !frame_done; i++) tick();
        chk("frame_done", {31'b0, frame_done}, 1);
        chk("req_count", req_idx, FW);
        any_req = 0;
        repeat (10) begin tick(); if (mem_req) any_req = 1; end
        chk("done_no_req", any_req, 0);

        // Drain buffered words, then pop on empty
        pix_pop = 1'b1;
        for (int i = 0; i < 60 && pix_valid; i++) tick();
        pix_pop = 1'b0;
        chk("drained_level", {26'b0, fifo_level}, 0);
        repeat (3) begin
            pix_pop = 1'b1;
            tick();
            pix_pop = 1'b0;
            chk("underrun_pulse", {31'b0, underrun}, 1);
            tick();
            chk("underrun_clear", {31'b0, underrun}, 0);
        end
        chk("underrun_level", {26'b0, fifo_level}, 0);
        chk("done_level_hold", {31'b0, frame_done}, 1);
`ifdef DISPLAY_PREFETCH_UNDERRUN_CNT_EN
        chk("underrun_cnt3", {16'b0, underrun_cnt}, 3);
`endif

        // Abort while a request is outstanding
        fixed_dly = 5;
        pulse_frame(24'h002000);
        for (int i = 0; i < 10 && !mem_req; i++) tick();
        chk("abort_req_up", {31'b0, mem_req}, 1);
        pulse_frame(24'h003000);
        chk("abort_req_held", {31'b0, mem_req}, 1);
        chk("abort_level", {26'b0, fifo_level}, 0);
        chk("abort_done_clr", {31'b0, frame_done}, 0);
        chk("abort_old_addr", {8'b0, mem_addr}, 32'h002000);
        fixed_dly = -1;
        for (int i = 0; i < 800 && !frame_done; i++) begin
            pix_pop = ($urandom % 3) != 0;
            tick();
        end
        pix_pop = 1'b0;
        chk("abort_frame_done", {31'b0, frame_done}, 1);

        // Randomized traffic with occasional mid-frame restarts
        for (int i = 0; i < 2500; i++) begin
            enable = ($urandom % 8) != 0;
            if ($urandom % 300 == 0) begin
                fb_base     = 24'($urandom);
                frame_start = 1'b1;
                pix_pop     = 1'b0;
            end else begin
                frame_start = 1'b0;
                pix_pop     = ($urandom % 2) != 0;
            end
            tick();
        end
        frame_start = 1'b0;
        pix_pop     = 1'b0;
        enable      = 1'b1;

        // Address wrap at the top of the word space
        pulse_frame(24'hFFFFFE);
        for (int i = 0; i < 800 && !frame_done; i++) begin
            pix_pop = ($urandom % 5) < 3;
            tick();
        end
        pix_pop = 1'b0;
        chk("wrap_frame_done", {31'b0, frame_done}, 1);
        chk("wrap_req_count", req_idx, FW);

        // Reset mid-transaction, then a stray ack must be ignored
        fixed_dly = 4;
        pulse_frame(24'h004000);
        for (int i = 0; i < 10 && !mem_req; i++) tick();
        rst_n = 1'b0;
        #2;
        chk("midrst_req",   {31'b0, mem_req}, 0);
        chk("midrst_level", {26'b0, fifo_level}, 0);
        chk("midrst_addr",  {8'b0, mem_addr}, 0);
        chk("midrst_valid", {31'b0, pix_valid}, 0);
        tick();
        rst_n     = 1'b1;
        fixed_dly = -1;
        stray_ack = 1;
        repeat (5) tick();
        chk("stray_ack_req",   {31'b0, mem_req}, 0);
        chk("stray_ack_level", {26'b0, fifo_level}, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
